// File: rtl/operand_pipeline_controller_pkg.sv
// Shared definitions for the operand path: second-operand selects, forwarding
// selects and the decoded control bundle carried from ID to WB.
package operand_pipeline_controller_pkg;

  typedef enum logic [2:0] {
    SI_PB       = 3'b000,
    SI_IMM12_I  = 3'b001,
    SI_IMM12_S  = 3'b010,
    SI_PC       = 3'b011,
    SI_IMM20    = 3'b100
  } si_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int unsigned CTRL_REG_ADDR_W = 5;
  localparam int unsigned CTRL_ALU_OP_W   = 4;

  typedef struct packed {
    logic                       valid;
    logic [2:0]                 si;
    logic [CTRL_ALU_OP_W-1:0]   alu_op;
    logic                       rf_le;
    logic                       load;
    logic [CTRL_REG_ADDR_W-1:0] rd;
  } ctrl_t;

endpackage

// File: rtl/operand_pipeline_controller_hazard_forward_unit.sv
// Combinational load-use detection and PA/PB forwarding selection.
module hazard_forward_unit
  import operand_pipeline_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic                  ex_rf_le,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_valid,
  input  logic                  mem_rf_le,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_rf_le,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  logic hz;

  // A load in EX cannot forward yet; its consumer waits a cycle and then picks MEM.
  function automatic logic [1:0] pick(
    input logic                  reads,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  ex_w,
    input logic [REG_ADDR_W-1:0] exd,
    input logic                  mem_w,
    input logic [REG_ADDR_W-1:0] memd,
    input logic                  wb_w,
    input logic [REG_ADDR_W-1:0] wbd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (reads) begin
      if (ex_w && exd != '0 && exd == rs)          sel = FWD_EX;
      else if (mem_w && memd != '0 && memd == rs)  sel = FWD_MEM;
      else if (wb_w && wbd != '0 && wbd == rs)     sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    hz = ex_valid && ex_load && (ex_rd != '0) && id_valid &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    stall = hz && !flush;
    fwd_a = pick(id_valid && id_uses_rs1, id_rs1,
                 ex_valid && ex_rf_le && !ex_load, ex_rd,
                 mem_valid && mem_rf_le, mem_rd,
                 wb_valid && wb_rf_le, wb_rd);
    fwd_b = pick(id_valid && id_uses_rs2, id_rs2,
                 ex_valid && ex_rf_le && !ex_load, ex_rd,
                 mem_valid && mem_rf_le, mem_rd,
                 wb_valid && wb_rf_le, wb_rd);
  end

endmodule

// File: rtl/operand_pipeline_controller.sv
// EX/MEM/WB control registers, load-use bubble insertion and stall counter.
module operand_pipeline_controller
  import operand_pipeline_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_OP_W   = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [2:0]            id_Si,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic                  id_rf_le,
  input  logic                  id_load,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [2:0]            ex_Si,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic                  ex_rf_le,
  output logic                  ex_load,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_rf_le,
  output logic                  mem_load,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_rf_le,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_count
);

  logic ex_take;

  hazard_forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_forward_unit (
    .id_valid    (id_valid),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_rf_le    (ex_rf_le),
    .ex_load     (ex_load),
    .ex_rd       (ex_rd),
    .mem_valid   (mem_valid),
    .mem_rf_le   (mem_rf_le),
    .mem_rd      (mem_rd),
    .wb_valid    (wb_valid),
    .wb_rf_le    (wb_rf_le),
    .wb_rd       (wb_rd),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  assign ex_take = id_valid && !stall && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_Si     <= SI_PB;
      ex_alu_op <= '0;
      ex_rf_le  <= 1'b0;
      ex_load   <= 1'b0;
      ex_rd     <= '0;
      mem_valid <= 1'b0;
      mem_rf_le <= 1'b0;
      mem_load  <= 1'b0;
      mem_rd    <= '0;
      wb_valid  <= 1'b0;
      wb_rf_le  <= 1'b0;
      wb_rd     <= '0;
      stall_count <= '0;
    end else begin
      wb_valid  <= mem_valid;
      wb_rf_le  <= mem_rf_le;
      wb_rd     <= mem_rd;
      mem_valid <= ex_valid;
      mem_rf_le <= ex_rf_le;
      mem_load  <= ex_load;
      mem_rd    <= ex_rd;
      if (ex_take) begin
        ex_valid  <= 1'b1;
        ex_Si     <= id_Si;
        ex_alu_op <= id_alu_op;
        ex_rf_le  <= id_rf_le;
        ex_load   <= id_load;
        ex_rd     <= id_rd;
      end else begin
        ex_valid  <= 1'b0;
        ex_Si     <= SI_PB;
        ex_alu_op <= '0;
        ex_rf_le  <= 1'b0;
        ex_load   <= 1'b0;
        ex_rd     <= '0;
      end
      if (stall && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_pipeline_controller.sv
// Directed vector bench for operand_pipeline_controller (stall counter narrowed to 4 bits).
module tb_operand_pipeline_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [2:0] id_Si = '0;
  logic [3:0] id_alu_op = '0;
  logic       id_rf_le = 1'b0;
  logic       id_load = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_uses_rs1 = 1'b0;
  logic       id_uses_rs2 = 1'b0;
  logic [4:0] id_rd = '0;
  logic       flush = 1'b0;
  logic       ex_valid, ex_rf_le, ex_load, mem_valid, mem_rf_le, mem_load;
  logic       wb_valid, wb_rf_le, stall;
  logic [2:0] ex_Si;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_count;

  int checks = 0;
  int errors = 0;

  operand_pipeline_controller #(.REG_ADDR_W(5), .ALU_OP_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_Si(id_Si), .id_alu_op(id_alu_op),
    .id_rf_le(id_rf_le), .id_load(id_load), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .flush(flush),
    .ex_valid(ex_valid), .ex_Si(ex_Si), .ex_alu_op(ex_alu_op), .ex_rf_le(ex_rf_le),
    .ex_load(ex_load), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_rf_le(mem_rf_le),
    .mem_load(mem_load), .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_rf_le(wb_rf_le),
    .wb_rd(wb_rd), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [2:0] si;
    logic       rfle;
    logic       load;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       fl;
    logic       e_stall;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
    logic       e_exv;
    logic [4:0] e_exrd;
    logic [2:0] e_exsi;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] si, input logic [3:0] alu,
                       input logic rfle, input logic ld, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic fl);
    id_valid = v; id_Si = si; id_alu_op = alu; id_rf_le = rfle; id_load = ld;
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd = rd; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_cnt;

  initial begin
    //          v  si    rf ld rs1 rs2 u1 u2 rd  fl | st fa     fb     exv exrd si     cnt
    vecs[0]  = '{1, 3'd1, 1, 0, 5'd1, 5'd0, 1, 0, 5'd5, 0, 0, 2'b00, 2'b00, 1, 5'd5, 3'd1, 4'd0};
    vecs[1]  = '{1, 3'd0, 1, 0, 5'd5, 5'd5, 1, 1, 5'd6, 0, 0, 2'b01, 2'b01, 1, 5'd6, 3'd0, 4'd0};
    vecs[2]  = '{1, 3'd1, 1, 1, 5'd2, 5'd0, 1, 0, 5'd7, 0, 0, 2'b00, 2'b00, 1, 5'd7, 3'd1, 4'd0};
    vecs[3]  = '{1, 3'd0, 1, 0, 5'd7, 5'd1, 1, 1, 5'd8, 0, 1, 2'b00, 2'b00, 0, 5'd0, 3'd0, 4'd1};
    vecs[4]  = '{1, 3'd0, 1, 0, 5'd7, 5'd1, 1, 1, 5'd8, 0, 0, 2'b10, 2'b00, 1, 5'd8, 3'd0, 4'd1};
    vecs[5]  = '{1, 3'd1, 1, 1, 5'd3, 5'd0, 1, 0, 5'd7, 0, 0, 2'b00, 2'b00, 1, 5'd7, 3'd1, 4'd1};
    vecs[6]  = '{1, 3'd0, 1, 0, 5'd7, 5'd1, 1, 1, 5'd8, 1, 0, 2'b00, 2'b00, 0, 5'd0, 3'd0, 4'd1};
    vecs[7]  = '{1, 3'd1, 1, 0, 5'd1, 5'd0, 1, 0, 5'd0, 0, 0, 2'b00, 2'b00, 1, 5'd0, 3'd1, 4'd1};
    vecs[8]  = '{1, 3'd1, 1, 0, 5'd1, 5'd0, 1, 0, 5'd0, 0, 0, 2'b00, 2'b00, 1, 5'd0, 3'd1, 4'd1};
    vecs[9]  = '{1, 3'd1, 1, 0, 5'd1, 5'd0, 1, 0, 5'd0, 0, 0, 2'b00, 2'b00, 1, 5'd0, 3'd1, 4'd1};
    vecs[10] = '{1, 3'd0, 1, 0, 5'd0, 5'd0, 1, 1, 5'd10, 0, 0, 2'b00, 2'b00, 1, 5'd10, 3'd0, 4'd1};
    vecs[11] = '{1, 3'd1, 1, 0, 5'd1, 5'd0, 1, 0, 5'd9, 0, 0, 2'b00, 2'b00, 1, 5'd9, 3'd1, 4'd1};
    vecs[12] = '{1, 3'd1, 1, 0, 5'd9, 5'd0, 1, 0, 5'd9, 0, 0, 2'b01, 2'b00, 1, 5'd9, 3'd1, 4'd1};
    vecs[13] = '{1, 3'd0, 1, 0, 5'd9, 5'd9, 1, 0, 5'd11, 0, 0, 2'b01, 2'b00, 1, 5'd11, 3'd0, 4'd1};
    vecs[14] = '{0, 3'd0, 1, 0, 5'd11, 5'd0, 1, 0, 5'd13, 0, 0, 2'b00, 2'b00, 0, 5'd0, 3'd0, 4'd1};
    vecs[15] = '{1, 3'd0, 1, 0, 5'd11, 5'd9, 1, 1, 5'd12, 0, 0, 2'b10, 2'b11, 1, 5'd12, 3'd0, 4'd1};

    // reset, then idle pipeline
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_a", fwd_a, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) tick();
    chk("idle_ex_valid", ex_valid, 0);
    chk("idle_mem_valid", mem_valid, 0);
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_ex_rd", ex_rd, 0);
    chk("idle_stall", stall, 0);
    chk("idle_fwd_a", fwd_a, 0);
    chk("idle_fwd_b", fwd_b, 0);
    chk("idle_cnt", stall_count, 0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].valid, vecs[i].si, 4'(i), vecs[i].rfle, vecs[i].load, vecs[i].rs1,
            vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd, vecs[i].fl);
      #3;
      chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d_fwd_a", i), fwd_a, vecs[i].e_fa);
      chk($sformatf("v%0d_fwd_b", i), fwd_b, vecs[i].e_fb);
      tick();
      chk($sformatf("v%0d_ex_valid", i), ex_valid, vecs[i].e_exv);
      chk($sformatf("v%0d_ex_rd", i), ex_rd, vecs[i].e_exrd);
      chk($sformatf("v%0d_ex_Si", i), ex_Si, vecs[i].e_exsi);
      chk($sformatf("v%0d_ex_alu_op", i), ex_alu_op, vecs[i].e_exv ? 4'(i) : 4'd0);
      chk($sformatf("v%0d_ex_load", i), ex_load, vecs[i].e_exv & vecs[i].load);
      chk($sformatf("v%0d_ex_rf_le", i), ex_rf_le, vecs[i].e_exv & vecs[i].rfle);
      chk($sformatf("v%0d_cnt", i), stall_count, vecs[i].e_cnt);
    end
    chk("tail_mem_valid", mem_valid, 0);
    chk("tail_wb_valid", wb_valid, 1);
    chk("tail_wb_rd", wb_rd, 11);
    chk("tail_wb_rf_le", wb_rf_le, 1);

    // repeated load-use pairs drive the counter into saturation
    exp_cnt = 4'd1;
    for (int p = 0; p < 16; p++) begin
      drive(1, 3'd1, 4'd2, 1, 1, 5'd2, 5'd0, 1, 0, 5'd7, 0);
      tick();
      chk("sat_mem_load", mem_load, 0);
      drive(1, 3'd0, 4'd0, 1, 0, 5'd7, 5'd1, 1, 1, 5'd8, 0);
      #3 chk($sformatf("sat%0d_stall", p), stall, 1);
      tick();
      exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'd1;
      chk($sformatf("sat%0d_cnt", p), stall_count, exp_cnt);
      chk("sat_bubble", ex_valid, 0);
      chk("sat_mem_load_lw", mem_load, 1);
      #3 chk($sformatf("sat%0d_fwd_a", p), fwd_a, 2'b10);
      chk("sat_no_restall", stall, 0);
      tick();
    end
    chk("sat_hold", stall_count, 4'hF);

    // asynchronous reset between edges
    drive(1, 3'd1, 4'd2, 1, 1, 5'd2, 5'd0, 1, 0, 5'd7, 0);
    tick();
    drive(1, 3'd0, 4'd0, 1, 0, 5'd7, 5'd1, 1, 1, 5'd8, 0);
    #1 chk("pre_rst_stall", stall, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_cnt", stall_count, 0);
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_mem_valid", mem_valid, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_stall", stall, 0);
    drive(0, 3'd0, 4'd0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("post_rst_cnt", stall_count, 0);
    chk("post_rst_ex_valid", ex_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
